// File: rtl/bcd_subtractor_seq_if.sv
// Handshake and operand/result bundle for the digit-serial packed-BCD subtractor.
// The controller drives the master side and the subtractor sits on the slave side.
interface bcd_subtractor_seq_if #(
   parameter int DIGITS = 4
);
   logic                  start;
   logic [4*DIGITS-1:0]   a;
   logic [4*DIGITS-1:0]   b;
   logic                  bin;
   logic [4*DIGITS-1:0]   diff;
   logic                  bout;
   logic                  busy;
   logic                  done;
   logic                  err;

   modport master (
      output start, a, b, bin,
      input  diff, bout, busy, done, err
   );

   modport slave (
      input  start, a, b, bin,
      output diff, bout, busy, done, err
   );
endinterface

// File: rtl/bcd_subtractor_seq.sv
// Digit-serial packed-BCD subtractor: A - B - bin, one decimal digit per clock, LSD first.
// A negative result is returned in ten's complement with bout set; bad operand digits raise err.
module bcd_subtractor_seq #(
   parameter int DIGITS = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   bcd_subtractor_seq_if.slave  bus
);
   localparam int W  = 4 * DIGITS;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_e;

   state_e           state_q, state_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic             borrow_q, borrow_d;
   logic [W-1:0]     a_q, a_d;
   logic [W-1:0]     b_q, b_d;
   logic [W-1:0]     diff_q, diff_d;
   logic             bout_q, bout_d;
   logic             err_q, err_d;

   logic [3:0]       a_dig;
   logic [3:0]       b_dig;
   logic [4:0]       t;
   logic [4:0]       t_adj;
   logic [3:0]       res_dig;

   // Checking the bus copy in the accept cycle equals checking the latched copy.
   function automatic logic has_bad_digit(input logic [W-1:0] x, input logic [W-1:0] y);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if ((x[4*i +: 4] > 4'd9) || (y[4*i +: 4] > 4'd9)) begin
            bad = 1'b1;
         end
      end
      return bad;
   endfunction

   // Current digit pair and its 5-bit two's-complement difference (range -10..9).
   always_comb begin
      // NOTE: every combinationally assigned signal gets a default first, so no path leaves it unassigned and no latch is inferred.
      a_dig = 4'd0;
      b_dig = 4'd0;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx_q == IW'(i)) begin
            a_dig = a_q[4*i +: 4];
            b_dig = b_q[4*i +: 4];
         end
      end
      t       = {1'b0, a_dig} - {1'b0, b_dig} - {4'b0000, borrow_q};
      t_adj   = t + 5'd10;
      res_dig = t[4] ? t_adj[3:0] : t[3:0];
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      borrow_d = borrow_q;
      a_d      = a_q;
      b_d      = b_q;
      diff_d   = diff_q;
      bout_d   = bout_q;
      err_d    = err_q;

      unique case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               a_d      = bus.a;
               b_d      = bus.b;
               borrow_d = bus.bin;
               diff_d   = '0;
               bout_d   = 1'b0;
               idx_d    = '0;
               if (has_bad_digit(bus.a, bus.b)) begin
                  err_d   = 1'b1;
                  state_d = S_DONE;
               end else begin
                  err_d   = 1'b0;
                  state_d = S_RUN;
               end
            end
         end

         S_RUN: begin
            for (int i = 0; i < DIGITS; i++) begin
               if (idx_q == IW'(i)) begin
                  diff_d[4*i +: 4] = res_dig;
               end
            end
            borrow_d = t[4];
            idx_d    = idx_q + IW'(1);
            if (idx_q == LAST_IDX) begin
               bout_d  = t[4];
               state_d = S_DONE;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         borrow_q <= 1'b0;
         diff_q   <= '0;
         bout_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         borrow_q <= borrow_d;
         diff_q   <= diff_d;
         bout_q   <= bout_d;
         err_q    <= err_d;
      end
   end

   // NOTE: operand copies are pure datapath, always reloaded on an accepted start, so they carry no reset.
   always_ff @(posedge clk) begin
      a_q <= a_d;
      b_q <= b_d;
   end

   assign bus.diff = diff_q;
   assign bus.bout = bout_q;
   assign bus.err  = err_q;
   assign bus.busy = (state_q != S_IDLE);
   assign bus.done = (state_q == S_DONE);

endmodule

// File: tb/tb_bcd_subtractor_seq.sv
// Self-checking bench for bcd_subtractor_seq: a 4-digit and a 1-digit instance checked
// against a decimal-integer reference model with directed and randomized operations.
module tb_bcd_subtractor_seq;
   logic clk;
   logic rst;
   int   total;
   int   bad;
   int   done_cnt4;

   bcd_subtractor_seq_if #(.DIGITS(4)) bus4 ();
   bcd_subtractor_seq_if #(.DIGITS(1)) bus1 ();

   bcd_subtractor_seq #(.DIGITS(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
   bcd_subtractor_seq #(.DIGITS(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(negedge clk) begin
      if (bus4.done === 1'b1) done_cnt4++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the decimal values, then back to BCD.
   function automatic void model(input logic [63:0] a, input logic [63:0] b, input logic bin,
                                 input int d, output logic [63:0] diff, output logic bout);
      longint va, vb, p, r;
      va = 0; vb = 0; p = 1;
      for (int i = 0; i < d; i++) begin
         va += longint'(a[4*i +: 4]) * p;
         vb += longint'(b[4*i +: 4]) * p;
         p  *= 10;
      end
      r    = va - vb - longint'(bin);
      bout = (r < 0);
      if (r < 0) r += p;
      diff = '0;
      for (int i = 0; i < d; i++) begin
         diff[4*i +: 4] = 4'(r % 10);
         r = r / 10;
      end
   endfunction

   function automatic logic any_bad(input logic [63:0] a, input logic [63:0] b, input int d);
      logic f;
      f = 1'b0;
      for (int i = 0; i < d; i++) if (a[4*i +: 4] > 9 || b[4*i +: 4] > 9) f = 1'b1;
      return f;
   endfunction

   function automatic logic [15:0] rand_bcd4();
      logic [15:0] r;
      for (int i = 0; i < 4; i++) r[4*i +: 4] = 4'($urandom_range(9, 0));
      return r;
   endfunction

   // One operation on the 4-digit instance, with expectations from the model.
   task automatic op4(input string tag, input logic [15:0] a, input logic [15:0] b, input logic bin);
      int          lat;
      int          busy_cnt;
      logic [63:0] exp_diff;
      logic        exp_bout;
      logic        exp_err;
      int          exp_lat;
      exp_err = any_bad({48'b0, a}, {48'b0, b}, 4);
      if (exp_err) begin
         exp_diff = '0; exp_bout = 1'b0; exp_lat = 1;
      end else begin
         model({48'b0, a}, {48'b0, b}, bin, 4, exp_diff, exp_bout);
         exp_lat = 5;
      end
      @(negedge clk);
      bus4.a = a; bus4.b = b; bus4.bin = bin; bus4.start = 1'b1;
      @(negedge clk);
      bus4.start = 1'b0;
      bus4.a = 16'($urandom); bus4.b = 16'($urandom); bus4.bin = 1'($urandom);
      lat = 1; busy_cnt = 0;
      while (bus4.done !== 1'b1 && lat < 40) begin
         busy_cnt += int'(bus4.busy === 1'b1);
         @(negedge clk);
         lat++;
      end
      busy_cnt += int'(bus4.busy === 1'b1);
      check({tag, ".lat"},  64'(lat), 64'(exp_lat));
      check({tag, ".busy"}, 64'(busy_cnt), 64'(exp_lat));
      check({tag, ".diff"}, {48'b0, bus4.diff}, exp_diff);
      check({tag, ".bout"}, 64'(bus4.bout), 64'(exp_bout));
      check({tag, ".err"},  64'(bus4.err), 64'(exp_err));
   endtask

   logic [15:0] opa [8];
   logic [15:0] opb [8];
   logic        opbin [8];
   int          dcyc [$];
   logic [15:0] ddiff [$];
   logic        dbout [$];

   initial begin
      logic [63:0] ed;
      logic        eb;
      logic [15:0] ra, rb;
      int          snap;
      int          lat;
      total = 0; bad = 0; done_cnt4 = 0;
      rst = 1'b1;
      bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.bin = 1'b0;
      bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.bin = 1'b0;
      repeat (3) @(negedge clk);
      check("rst.diff", {48'b0, bus4.diff}, 64'h0);
      check("rst.bout", 64'(bus4.bout), 64'h0);
      check("rst.busy", 64'(bus4.busy), 64'h0);
      check("rst.done", 64'(bus4.done), 64'h0);
      check("rst.err",  64'(bus4.err),  64'h0);
      rst = 1'b0;

      // Basic subtraction and the idle cycle after done.
      op4("basic", 16'h1234, 16'h0567, 1'b0);
      @(negedge clk);
      check("basic.after_done", 64'(bus4.done), 64'h0);
      check("basic.after_busy", 64'(bus4.busy), 64'h0);
      check("basic.hold_diff", {48'b0, bus4.diff}, 64'h0667);

      // Wrap-around with borrow.
      op4("wrap0", 16'h0000, 16'h0001, 1'b0);
      op4("wrap9", 16'h9999, 16'h9999, 1'b1);
      op4("zero",  16'h4321, 16'h4321, 1'b0);

      // Invalid digit, then a valid op back to back.
      op4("inval", 16'h12A4, 16'h0001, 1'b0);
      op4("after_inval", 16'h0010, 16'h0001, 1'b0);
      op4("inval_b", 16'h0000, 16'hF000, 1'b1);

      // Start held for 8 cycles with operands changing each cycle.
      for (int c = 0; c < 8; c++) begin
         opa[c] = rand_bcd4(); opb[c] = rand_bcd4(); opbin[c] = 1'($urandom);
      end
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         if (bus4.done === 1'b1) begin
            dcyc.push_back(c); ddiff.push_back(bus4.diff); dbout.push_back(bus4.bout);
         end
         if (c < 8) begin
            bus4.start = 1'b1; bus4.a = opa[c]; bus4.b = opb[c]; bus4.bin = opbin[c];
         end else begin
            bus4.start = 1'b0;
         end
      end
      check("hold.count", 64'(dcyc.size()), 64'd2);
      if (dcyc.size() >= 2) begin
         check("hold.cyc0", 64'(dcyc[0]), 64'd5);
         check("hold.cyc1", 64'(dcyc[1]), 64'd11);
         model({48'b0, opa[0]}, {48'b0, opb[0]}, opbin[0], 4, ed, eb);
         check("hold.diff0", {48'b0, ddiff[0]}, ed);
         check("hold.bout0", 64'(dbout[0]), 64'(eb));
         model({48'b0, opa[6]}, {48'b0, opb[6]}, opbin[6], 4, ed, eb);
         check("hold.diff1", {48'b0, ddiff[1]}, ed);
         check("hold.bout1", 64'(dbout[1]), 64'(eb));
      end

      // Reset during the second RUN cycle discards the operation.
      @(negedge clk);
      bus4.a = 16'h9876; bus4.b = 16'h1234; bus4.bin = 1'b1; bus4.start = 1'b1;
      @(negedge clk);
      bus4.start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mrst.busy", 64'(bus4.busy), 64'h0);
      check("mrst.done", 64'(bus4.done), 64'h0);
      check("mrst.diff", {48'b0, bus4.diff}, 64'h0);
      check("mrst.bout", 64'(bus4.bout), 64'h0);
      check("mrst.err",  64'(bus4.err),  64'h0);
      snap = done_cnt4;
      repeat (8) @(negedge clk);
      check("mrst.no_done", 64'(done_cnt4), 64'(snap));
      op4("after_rst", 16'h5000, 16'h0001, 1'b0);

      // Randomized operations, mostly valid with occasional bad digits.
      for (int n = 0; n < 40; n++) begin
         ra = rand_bcd4(); rb = rand_bcd4();
         if ($urandom_range(7, 0) == 0) ra[4*$urandom_range(3, 0) +: 4] = 4'($urandom_range(15, 10));
         if ($urandom_range(7, 0) == 0) rb[4*$urandom_range(3, 0) +: 4] = 4'($urandom_range(15, 10));
         op4("rand", ra, rb, 1'($urandom));
      end

      // Exhaustive single-digit sweep on the 1-digit instance.
      for (int a = 0; a < 10; a++) begin
         for (int b = 0; b < 10; b++) begin
            for (int bi = 0; bi < 2; bi++) begin
               model(64'(a), 64'(b), 1'(bi), 1, ed, eb);
               @(negedge clk);
               bus1.a = 4'(a); bus1.b = 4'(b); bus1.bin = 1'(bi); bus1.start = 1'b1;
               @(negedge clk);
               bus1.start = 1'b0; bus1.a = 4'($urandom); bus1.b = 4'($urandom);
               lat = 1;
               while (bus1.done !== 1'b1 && lat < 20) begin
                  @(negedge clk);
                  lat++;
               end
               check("d1.lat",  64'(lat), 64'd2);
               check("d1.diff", {60'b0, bus1.diff}, ed);
               check("d1.bout", 64'(bus1.bout), 64'(eb));
               check("d1.err",  64'(bus1.err), 64'h0);
            end
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
